button_debounce: RTL and testbench

Debounce and edge-detect stage that sits directly upstream of the electronic dice. It conditions the raw mechanical push-button into a clean level that drives the dice's `button` input, so the dice rolls only while a genuine press is held. It also emits single-cycle press and release pulses and a saturating count of rejected bounces for the display and status logic.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_debounce.sv | 108 ++++++++++
 tb/tb_button_debounce.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debounce stage.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int unsigned BOUNCE_CNT_W        = 8;
  localparam logic [BOUNCE_CNT_W-1:0] BOUNCE_CNT_MAX = 8'd255;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset, flops clear to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debounce with press/release pulses and a saturating bounce count.
// Define BUTTON_SYNC_EN to insert a 2-flop synchronizer ahead of the FSM.
//
// state        | meaning
// -------------+-------------------------------------------------
// IDLE         | clean level 0, input low, cnt = 0
// PRESS_WAIT   | clean level 0, counting consecutive high samples
// PRESSED      | clean level 1, input high, cnt = 0
// RELEASE_WAIT | clean level 1, counting consecutive low samples
module button_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    button_raw,
  output logic                    button_clean,
  output logic                    press_pulse,
  output logic                    release_pulse,
  output logic [BOUNCE_CNT_W-1:0] bounce_cnt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             s;

`ifdef BUTTON_SYNC_EN
  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (s)
  );
`else
  assign s = button_raw;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      button_clean  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      bounce_cnt    <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
            if (bounce_cnt != BOUNCE_CNT_MAX)
              bounce_cnt <= bounce_cnt + BOUNCE_CNT_W'(1);
          end else if (cnt == CNT_LAST) begin
            state        <= PRESSED;
            cnt          <= '0;
            button_clean <= 1'b1;
            press_pulse  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          // a high sample here is a bounce back to the held level
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
            if (bounce_cnt != BOUNCE_CNT_MAX)
              bounce_cnt <= bounce_cnt + BOUNCE_CNT_W'(1);
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            button_clean  <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (DEBOUNCE_CYCLES = 4), with a run-length reference model.
// Honours BUTTON_SYNC_EN by delaying the model input by two samples.
module tb_button_debounce;

  localparam int unsigned D = 4;
`ifdef BUTTON_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button_raw = 1'b0;
  logic       button_clean;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] bounce_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: clean level, length of current run opposing it, bounce tally
  logic m_clean, m_press, m_release, m_p1, m_p2;
  int   m_run, m_bounce;

  button_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .button_raw    (button_raw),
    .button_clean  (button_clean),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .bounce_cnt    (bounce_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_clean = 0; m_press = 0; m_release = 0;
    m_p1 = 0; m_p2 = 0; m_run = 0; m_bounce = 0;
  endtask

  task automatic model_edge(input logic b);
    logic sv;
    if (SYNC_LAT == 2) begin
      sv = m_p2; m_p2 = m_p1; m_p1 = b;
    end else begin
      sv = b;
    end
    m_press = 0; m_release = 0;
    if (sv != m_clean) begin
      m_run++;
      if (m_run == int'(D)) begin
        m_clean = ~m_clean;
        m_run = 0;
        if (m_clean) m_press = 1; else m_release = 1;
      end
    end else if (m_run > 0) begin
      m_run = 0;
      if (m_bounce < 255) m_bounce++;
    end
  endtask

  // drive one sample, let one edge pass, leave time at edge+1
  task automatic step(input logic b);
    button_raw = b;
    @(posedge clk);
    model_edge(b);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    button_raw = 1'b0;
    do_reset();
    n_checks++;
    if (button_clean !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: clean=%b press=%b release=%b, want 0 0 0",
               button_clean, press_pulse, release_pulse);
    end
    n_checks++;
    if (bounce_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_bounce: got %0d want 0", bounce_cnt);
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    for (int i = 0; i < int'(D) + SYNC_LAT + 2; i++) begin
      step(1'b1);
      n_checks++;
      if (button_clean !== (i >= int'(D) - 1 + SYNC_LAT)) begin
        n_errors++;
        $display("FAIL clean_press_level edge %0d: got %b want %b", i, button_clean,
                 (i >= int'(D) - 1 + SYNC_LAT));
      end
      n_checks++;
      if (press_pulse !== (i == int'(D) - 1 + SYNC_LAT)) begin
        n_errors++;
        $display("FAIL clean_press_pulse edge %0d: got %b want %b", i, press_pulse,
                 (i == int'(D) - 1 + SYNC_LAT));
      end
    end
    n_checks++;
    if (bounce_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL clean_press_bounce: got %0d want 0", bounce_cnt);
    end
  endtask

  task automatic test_bouncy_press();
    logic [8:0] pat;
    int presses = 0;
    pat = 9'b1_1110_1101; // applied LSB first: 1,0,1,1,0,1,1,1,1
    do_reset();
    for (int i = 0; i < 9 + SYNC_LAT; i++) begin
      step(i < 9 ? pat[i] : 1'b1);
      if (press_pulse) presses++;
      n_checks++;
      if (button_clean !== m_clean) begin
        n_errors++;
        $display("FAIL bouncy_level edge %0d: got %b want %b", i, button_clean, m_clean);
      end
    end
    n_checks++;
    if (button_clean !== 1'b1 || presses != 1) begin
      n_errors++;
      $display("FAIL bouncy_result: clean=%b presses=%0d, want 1 and 1", button_clean, presses);
    end
    n_checks++;
    if (bounce_cnt !== 8'd2) begin
      n_errors++;
      $display("FAIL bouncy_bounce: got %0d want 2", bounce_cnt);
    end
  endtask

  task automatic test_release();
    int releases = 0;
    logic [7:0] b0;
    // continues from the pressed state left by test_bouncy_press
    b0 = bounce_cnt;
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 0; i < 4 + SYNC_LAT; i++) begin
      step(1'b1);
      if (release_pulse) releases++;
    end
    n_checks++;
    if (button_clean !== 1'b1 || releases != 0) begin
      n_errors++;
      $display("FAIL release_glitch: clean=%b releases=%0d, want 1 and 0", button_clean, releases);
    end
    n_checks++;
    if (bounce_cnt !== b0 + 8'd1) begin
      n_errors++;
      $display("FAIL release_glitch_bounce: got %0d want %0d", bounce_cnt, b0 + 8'd1);
    end
    for (int i = 0; i < int'(D) + SYNC_LAT + 1; i++) begin
      step(1'b0);
      n_checks++;
      if (release_pulse !== (i == int'(D) - 1 + SYNC_LAT)) begin
        n_errors++;
        $display("FAIL release_pulse edge %0d: got %b want %b", i, release_pulse,
                 (i == int'(D) - 1 + SYNC_LAT));
      end
      n_checks++;
      if (press_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL release_no_press edge %0d: got %b want 0", i, press_pulse);
      end
    end
    n_checks++;
    if (button_clean !== 1'b0) begin
      n_errors++;
      $display("FAIL release_level: got %b want 0", button_clean);
    end
  endtask

  task automatic test_saturation();
    int highs = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      if (button_clean) highs++;
      step(1'b0);
      if (button_clean) highs++;
    end
    for (int i = 0; i < SYNC_LAT + 1; i++) step(1'b0);
    n_checks++;
    if (bounce_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL saturation_count: got %0d want 255", bounce_cnt);
    end
    n_checks++;
    if (highs != 0 || button_clean !== 1'b0) begin
      n_errors++;
      $display("FAIL saturation_level: high cycles %0d, want 0", highs);
    end
  endtask

  task automatic test_reset_mid_wait();
    int fire_edge = -1;
    do_reset();
    step(1'b1); step(1'b0);                 // one aborted window
    for (int i = 0; i < SYNC_LAT; i++) step(1'b0);
    for (int i = 0; i < 2 + SYNC_LAT; i++) step(1'b1); // PRESS_WAIT, cnt = 2
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (button_clean !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0 ||
        bounce_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_mid_press_wait: clean=%b press=%b release=%b bounce=%0d, want all 0",
               button_clean, press_pulse, release_pulse, bounce_cnt);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (press_pulse && fire_edge < 0) fire_edge = i;
    end
    n_checks++;
    if (fire_edge != 3 + SYNC_LAT) begin
      n_errors++;
      $display("FAIL reset_restart_latency: press at edge %0d want %0d", fire_edge, 3 + SYNC_LAT);
    end
    // now clean = 1; reset inside RELEASE_WAIT must drop it asynchronously
    for (int i = 0; i < 2 + SYNC_LAT; i++) step(1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (button_clean !== 1'b0 || release_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_release_wait: clean=%b release=%b, want 0 0",
               button_clean, release_pulse);
    end
    model_reset();
    button_raw = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int len;
    for (int r = 0; r < 400; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        step(lvl);
        n_checks++;
        if (button_clean !== m_clean || press_pulse !== m_press ||
            release_pulse !== m_release || bounce_cnt !== 8'(m_bounce)) begin
          n_errors++;
          $display("FAIL random run %0d: clean/press/rel/bounce got %b%b%b/%0d want %b%b%b/%0d",
                   r, button_clean, press_pulse, release_pulse, bounce_cnt,
                   m_clean, m_press, m_release, m_bounce);
        end
        n_checks++;
        if (press_pulse && release_pulse) begin
          n_errors++;
          $display("FAIL random_pulse_overlap run %0d: got both high want at most one", r);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_release();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
